// File: rtl/vc_entry_array.sv
// Victim cache storage core: fully-associative line array with combinational lookup,
// invalid-first/round-robin replacement and a one-entry dirty writeback buffer to L2.
module vc_entry_array #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic              lookup_wb,
  output logic [IDX_W-1:0]  lookup_idx,
  output logic [DATA_W-1:0] lookup_data,
  output logic              lookup_dirty,
  input  logic              take,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              ins_dirty,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [IDX_W:0]    occupancy
);

  localparam int unsigned OCC_W = IDX_W + 1;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_entries_check
    $error("vc_entry_array: ENTRIES must be a power of 2 and at least 2");
  end
  if (IDX_W != $clog2(ENTRIES)) begin : g_idx_w_check
    $error("vc_entry_array: IDX_W is derived from ENTRIES and must not be overridden");
  end

  typedef enum logic {
    WB_EMPTY,
    WB_FULL
  } wb_state_e;

  typedef enum logic [1:0] {
    INS_OVERWRITE,
    INS_SWAP,
    INS_FILL,
    INS_EVICT
  } ins_kind_e;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] dirty_q;
  logic [ADDR_W-1:0]  addr_q [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  wb_state_e          wb_state_q;
  logic [ADDR_W-1:0]  wb_addr_q;
  logic [DATA_W-1:0]  wb_data_q;

  logic               arr_hit;
  logic [IDX_W-1:0]   arr_idx;
  logic               wb_hit;
  logic               ins_match;
  logic [IDX_W-1:0]   ins_match_idx;
  logic               any_free;
  logic [IDX_W-1:0]   free_idx;
  logic               all_valid;
  logic               ins_fire;
  logic               take_arr;
  logic               take_wb;
  logic               ins_hits_wb;
  ins_kind_e          ins_kind;
  logic [IDX_W-1:0]   ins_tgt;
  logic               evict;
  logic               evict_dirty;
  logic               occ_inc;
  logic               occ_dec;

  // Associative search of the array for the L1 lookup address.
  always_comb begin
    arr_hit = 1'b0;
    arr_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && addr_q[i] == lookup_addr) begin
        arr_hit = 1'b1;
        arr_idx = IDX_W'(i);
      end
    end
  end

  // Associative search for the insert address (dedupe target).
  always_comb begin
    ins_match     = 1'b0;
    ins_match_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && addr_q[i] == ins_addr) begin
        ins_match     = 1'b1;
        ins_match_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid slot; scanning downward lets the lowest one win.
  always_comb begin
    free_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign any_free  = ~&valid_q;
  assign all_valid = &valid_q;
  assign wb_valid  = (wb_state_q == WB_FULL);
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign occupancy = occ_q;

  // Depends only on registered state, so it may stall an insert that would not evict.
  assign ins_ready = !(wb_valid && all_valid && dirty_q[rr_ptr_q]);

  assign wb_hit       = wb_valid && (wb_addr_q == lookup_addr);
  assign lookup_hit   = arr_hit || wb_hit;
  assign lookup_wb    = !arr_hit && wb_hit;
  assign lookup_idx   = arr_idx;
  assign lookup_data  = arr_hit ? data_q[arr_idx] : (wb_hit ? wb_data_q : '0);
  assign lookup_dirty = arr_hit ? dirty_q[arr_idx] : wb_hit;

  assign ins_fire    = ins_valid && ins_ready;
  assign take_arr    = take && arr_hit;
  assign take_wb     = take && lookup_wb;
  assign ins_hits_wb = ins_fire && wb_valid && (ins_addr == wb_addr_q);

  // Insert target selection in priority order.
  always_comb begin
    ins_kind = INS_EVICT;
    ins_tgt  = rr_ptr_q;
    if (ins_match) begin
      ins_kind = INS_OVERWRITE;
      ins_tgt  = ins_match_idx;
    end else if (take_arr) begin
      ins_kind = INS_SWAP;
      ins_tgt  = arr_idx;
    end else if (any_free) begin
      ins_kind = INS_FILL;
      ins_tgt  = free_idx;
    end
  end

  assign evict       = ins_fire && (ins_kind == INS_EVICT);
  assign evict_dirty = evict && dirty_q[rr_ptr_q];
  assign occ_inc     = ins_fire && (ins_kind == INS_FILL);
  assign occ_dec     = take_arr && !(ins_fire && ins_tgt == arr_idx);

  // Valid/dirty, replacement pointer and occupancy; insert overrides a same-slot take.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      rr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (take_arr) begin
        valid_q[arr_idx] <= 1'b0;
        dirty_q[arr_idx] <= 1'b0;
      end
      if (ins_fire) begin
        valid_q[ins_tgt] <= 1'b1;
        dirty_q[ins_tgt] <= ins_dirty || (ins_kind == INS_OVERWRITE && dirty_q[ins_tgt]);
      end
      if (evict) begin
        rr_ptr_q <= rr_ptr_q + IDX_W'(1);
      end
      occ_q <= occ_q + OCC_W'(occ_inc) - OCC_W'(occ_dec);
    end
  end

  // Line payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (ins_fire) begin
      addr_q[ins_tgt] <= ins_addr;
      data_q[ins_tgt] <= ins_data;
    end
  end

  // Writeback buffer FSM; a dirty eviction reloads even while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_state_q <= WB_EMPTY;
    end else begin
      case (wb_state_q)
        WB_EMPTY: begin
          if (evict_dirty) begin
            wb_state_q <= WB_FULL;
            wb_addr_q  <= addr_q[rr_ptr_q];
            wb_data_q  <= data_q[rr_ptr_q];
          end
        end
        WB_FULL: begin
          if (evict_dirty) begin
            wb_addr_q <= addr_q[rr_ptr_q];
            wb_data_q <= data_q[rr_ptr_q];
          end else if (wb_ready || take_wb || ins_hits_wb) begin
            wb_state_q <= WB_EMPTY;
          end
        end
        default: wb_state_q <= WB_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_entry_array.sv
// Bench for vc_entry_array: directed vector table, reset-mid-transfer sequence,
// then randomized traffic against an array-of-lines reference model.
module tb_vc_entry_array;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned IDX_W   = 3;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic              lookup_wb;
  logic [IDX_W-1:0]  lookup_idx;
  logic [DATA_W-1:0] lookup_data;
  logic              lookup_dirty;
  logic              take;
  logic              ins_valid;
  logic              ins_ready;
  logic [ADDR_W-1:0] ins_addr;
  logic [DATA_W-1:0] ins_data;
  logic              ins_dirty;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [IDX_W:0]    occupancy;

  vc_entry_array #(
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_wb   (lookup_wb),
    .lookup_idx  (lookup_idx),
    .lookup_data (lookup_data),
    .lookup_dirty(lookup_dirty),
    .take        (take),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_addr    (ins_addr),
    .ins_data    (ins_data),
    .ins_dirty   (ins_dirty),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dat(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'h5a5a_0000}};
  endfunction

  typedef struct {
    logic              iv;
    logic [ADDR_W-1:0] ia;
    logic              idt;
    logic              tk;
    logic [ADDR_W-1:0] la;
    logic              wr;
    logic              e_hit;
    logic              e_wb;
    logic [IDX_W-1:0]  e_idx;
    logic              e_dirty;
    logic              e_inv;
    logic              e_rdy;
    logic              e_wbv;
    logic [ADDR_W-1:0] e_wba;
    logic [IDX_W:0]    e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int iv, int ia, int idt, int tk, int la, int wr,
                              int hit, int wb, int idx, int dirty, int inv,
                              int rdy, int wbv, int wba, int occ);
    vec_t v;
    v.iv = 1'(iv);       v.ia = 32'(ia);      v.idt = 1'(idt);   v.tk = 1'(tk);
    v.la = 32'(la);      v.wr = 1'(wr);       v.e_hit = 1'(hit); v.e_wb = 1'(wb);
    v.e_idx = 3'(idx);   v.e_dirty = 1'(dirty); v.e_inv = 1'(inv);
    v.e_rdy = 1'(rdy);   v.e_wbv = 1'(wbv);   v.e_wba = 32'(wba); v.e_occ = 4'(occ);
    return v;
  endfunction

  task automatic idle_inputs();
    take = 1'b0; ins_valid = 1'b0; ins_addr = '0; ins_data = '0; ins_dirty = 1'b0;
    wb_ready = 1'b0; lookup_addr = '0;
  endtask

  // Reference model: one record per line plus the writeback buffer.
  bit                m_v  [ENTRIES];
  logic [ADDR_W-1:0] m_a  [ENTRIES];
  logic [DATA_W-1:0] m_d  [ENTRIES];
  bit                m_dt [ENTRIES];
  int                m_rr;
  bit                m_wbv;
  logic [ADDR_W-1:0] m_wba;
  logic [DATA_W-1:0] m_wbd;

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 0; m_dt[i] = 0; m_a[i] = '0; m_d[i] = '0;
    end
    m_rr = 0; m_wbv = 0; m_wba = '0; m_wbd = '0;
  endtask

  function automatic logic [ADDR_W-1:0] pool_addr();
    return 32'($urandom_range(0, 11)) << 6;
  endfunction

  task automatic random_cycle();
    int  hidx, mi, fi, tgt, cnt;
    bit  wbh, all_v, rdy, fire, t_arr, t_wb, nd, wbv_n;
    logic [ADDR_W-1:0] vic_a;
    logic [DATA_W-1:0] vic_d, exp_d;
    bit vic_dirty, do_evict;

    rst         = ($urandom_range(0, 299) == 0);
    lookup_addr = pool_addr();
    take        = ($urandom_range(0, 3) == 0);
    ins_valid   = 1'($urandom_range(0, 1));
    ins_addr    = pool_addr();
    ins_dirty   = 1'($urandom_range(0, 1));
    for (int k = 0; k < 8; k++) ins_data[k*32 +: 32] = $urandom;
    wb_ready    = ($urandom_range(0, 2) == 0);

    @(negedge clk);
    hidx = -1;
    for (int i = 0; i < ENTRIES; i++) if (m_v[i] && m_a[i] == lookup_addr) hidx = i;
    wbh = (hidx < 0) && m_wbv && (m_wba == lookup_addr);
    all_v = 1; cnt = 0;
    for (int i = 0; i < ENTRIES; i++) begin all_v &= m_v[i]; cnt += int'(m_v[i]); end
    rdy = !(m_wbv && all_v && m_dt[m_rr]);
    exp_d = (hidx >= 0) ? m_d[hidx] : (wbh ? m_wbd : '0);

    chk("rnd_hit",   DATA_W'(lookup_hit),   DATA_W'((hidx >= 0) || wbh));
    chk("rnd_wb",    DATA_W'(lookup_wb),    DATA_W'(wbh));
    chk("rnd_idx",   DATA_W'(lookup_idx),   DATA_W'((hidx >= 0) ? hidx : 0));
    chk("rnd_data",  lookup_data,           exp_d);
    chk("rnd_dirty", DATA_W'(lookup_dirty), DATA_W'((hidx >= 0) ? m_dt[hidx] : wbh));
    chk("rnd_ready", DATA_W'(ins_ready),    DATA_W'(rdy));
    chk("rnd_wbv",   DATA_W'(wb_valid),     DATA_W'(m_wbv));
    chk("rnd_occ",   DATA_W'(occupancy),    DATA_W'(cnt));
    if (m_wbv) begin
      chk("rnd_wba", DATA_W'(wb_addr), DATA_W'(m_wba));
      chk("rnd_wbd", wb_data, m_wbd);
    end

    if (rst) begin
      model_reset();
    end else begin
      fire  = ins_valid && rdy;
      t_arr = take && (hidx >= 0);
      t_wb  = take && wbh;
      mi = -1; fi = -1;
      for (int i = 0; i < ENTRIES; i++) if (m_v[i] && m_a[i] == ins_addr) mi = i;
      for (int i = ENTRIES - 1; i >= 0; i--) if (!m_v[i]) fi = i;

      tgt = -1; nd = ins_dirty; do_evict = 0; vic_dirty = 0; vic_a = '0; vic_d = '0;
      if (fire) begin
        if (mi >= 0) begin
          tgt = mi; nd = m_dt[mi] | ins_dirty;
        end else if (t_arr) begin
          tgt = hidx;
        end else if (fi >= 0) begin
          tgt = fi;
        end else begin
          tgt = m_rr; do_evict = 1;
          vic_dirty = m_dt[m_rr]; vic_a = m_a[m_rr]; vic_d = m_d[m_rr];
        end
      end

      wbv_n = m_wbv;
      if (m_wbv && wb_ready) wbv_n = 0;
      if (t_wb) wbv_n = 0;
      if (fire && m_wbv && ins_addr == m_wba) wbv_n = 0;
      if (do_evict && vic_dirty) begin
        wbv_n = 1; m_wba = vic_a; m_wbd = vic_d;
      end
      m_wbv = wbv_n;

      if (t_arr) begin m_v[hidx] = 0; m_dt[hidx] = 0; end
      if (tgt >= 0) begin
        m_v[tgt] = 1; m_a[tgt] = ins_addr; m_d[tgt] = ins_data; m_dt[tgt] = nd;
      end
      if (do_evict) m_rr = (m_rr + 1) % ENTRIES;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Fill, dedupe, dirty eviction, backpressure, swap, take, wb hit/take, wb supersede.
    vecs.push_back(mk(0, 'h000,  0, 0, 'h000,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h000,  0, 0, 'h000,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(1, 'h100 * i, 0, 0, 'h100 * (i - 1), 0, 1, 0, i - 1, 0, 0, 1, 0, 0, i));
    vecs.push_back(mk(1, 'h000,  1, 0, 'h700,  0, 1, 0, 7, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h000,  0, 1, 0, 0, 1, 1, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'hA000, 0, 0, 'h000,  0, 1, 0, 0, 1, 1, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'hA000, 0, 1, 0, 0, 0, 0, 1, 1, 'h000, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h000,  0, 1, 1, 0, 1, 1, 1, 1, 'h000, 8));
    vecs.push_back(mk(1, 'h100,  1, 0, 'h100,  0, 1, 0, 1, 0, 0, 1, 1, 'h000, 8));
    vecs.push_back(mk(1, 'hC000, 0, 0, 'h100,  0, 1, 0, 1, 1, 1, 0, 1, 'h000, 8));
    vecs.push_back(mk(1, 'hC000, 0, 0, 'hC000, 1, 0, 0, 0, 0, 0, 0, 1, 'h000, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h000,  0, 0, 0, 0, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'hB00,  0, 1, 'h300,  0, 1, 0, 3, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h300,  0, 0, 0, 0, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 1, 'hB00,  0, 1, 0, 3, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'hB00,  0, 0, 0, 0, 0, 0, 1, 0, 0, 7));
    vecs.push_back(mk(1, 'hD00,  1, 0, 'h700,  0, 1, 0, 7, 0, 0, 1, 0, 0, 7));
    vecs.push_back(mk(0, 0,      0, 0, 'hD00,  0, 1, 0, 3, 1, 1, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'hE000, 0, 0, 'h200,  0, 1, 0, 2, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 1, 'h100,  0, 1, 1, 0, 1, 1, 1, 1, 'h100, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h100,  0, 0, 0, 0, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'hF000, 0, 0, 'h200,  0, 1, 0, 2, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h200,  0, 0, 0, 0, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'h10000,0, 0, 'hD00,  0, 1, 0, 3, 1, 1, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'hD00,  0, 1, 1, 0, 1, 1, 1, 1, 'hD00, 8));
    vecs.push_back(mk(1, 'hD00,  0, 0, 'hD00,  0, 1, 1, 0, 1, 1, 1, 1, 'hD00, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'hD00,  0, 1, 0, 4, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'h500,  1, 0, 'h500,  0, 1, 0, 5, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(1, 'h30000,0, 0, 'h500,  0, 1, 0, 5, 1, 1, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0,      0, 0, 'h500,  0, 1, 1, 0, 1, 1, 1, 1, 'h500, 8));

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[r]) begin
      vec_t v;
      logic [DATA_W-1:0] exp_d;
      v = vecs[r];
      ins_valid   = v.iv;
      ins_addr    = v.ia;
      ins_dirty   = v.idt;
      ins_data    = dat(v.ia) ^ {DATA_W{v.idt}};
      take        = v.tk;
      lookup_addr = v.la;
      wb_ready    = v.wr;
      @(negedge clk);
      exp_d = v.e_hit ? (dat(v.la) ^ {DATA_W{v.e_inv}}) : '0;
      chk($sformatf("vec%0d_hit", r),   DATA_W'(lookup_hit),   DATA_W'(v.e_hit));
      chk($sformatf("vec%0d_wb", r),    DATA_W'(lookup_wb),    DATA_W'(v.e_wb));
      chk($sformatf("vec%0d_idx", r),   DATA_W'(lookup_idx),   DATA_W'(v.e_idx));
      chk($sformatf("vec%0d_dirty", r), DATA_W'(lookup_dirty), DATA_W'(v.e_dirty));
      chk($sformatf("vec%0d_data", r),  lookup_data,           exp_d);
      chk($sformatf("vec%0d_ready", r), DATA_W'(ins_ready),    DATA_W'(v.e_rdy));
      chk($sformatf("vec%0d_wbv", r),   DATA_W'(wb_valid),     DATA_W'(v.e_wbv));
      chk($sformatf("vec%0d_occ", r),   DATA_W'(occupancy),    DATA_W'(v.e_occ));
      if (v.e_wbv) begin
        chk($sformatf("vec%0d_wba", r), DATA_W'(wb_addr), DATA_W'(v.e_wba));
        chk($sformatf("vec%0d_wbd", r), wb_data, ~dat(v.e_wba));
      end
      @(posedge clk); #1;
    end

    // Reset while the array is full and the writeback buffer holds 0x500.
    idle_inputs();
    lookup_addr = 32'h500;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hit",   DATA_W'(lookup_hit),   '0);
    chk("rst_wb",    DATA_W'(lookup_wb),    '0);
    chk("rst_idx",   DATA_W'(lookup_idx),   '0);
    chk("rst_data",  lookup_data,           '0);
    chk("rst_dirty", DATA_W'(lookup_dirty), '0);
    chk("rst_wbv",   DATA_W'(wb_valid),     '0);
    chk("rst_occ",   DATA_W'(occupancy),    '0);
    chk("rst_ready", DATA_W'(ins_ready),    DATA_W'(1));
    lookup_addr = 32'h30000;
    @(negedge clk);
    chk("rst_hit2",  DATA_W'(lookup_hit),   '0);
    @(posedge clk); #1;

    model_reset();
    for (int n = 0; n < 4000; n++) random_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
